// File: rtl/avg_pkg.sv
// Shared definitions for the averaging sequencer: FSM encoding, bus widths
// and the rounding rule applied to the adder-tree result.
package avg_pkg;

    localparam int ADDR_W = 5;
    localparam int SUM_W  = 16;
    localparam int AVG_W  = 8;

    // Half of the 256-sample divisor, so the shift rounds to nearest.
    localparam logic [SUM_W:0] ROUND_CONST = 17'd128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Worst real sum is 8 lanes x 32 beats x 255 = 65280, so the rounded
    // result always fits in 8 bits.
    function automatic logic [AVG_W-1:0] round_avg(input logic [SUM_W-1:0] sum);
        return AVG_W'(({1'b0, sum} + ROUND_CONST) >> 8);
    endfunction

endpackage

// File: rtl/avg_sequencer_if.sv
// Memory read and adder-tree control bus between the sequencer and the
// datapath that owns the sample memory and the adder tree.
interface avg_sequencer_if;
    import avg_pkg::*;

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              tree_clr;
    logic              tree_valid;
    logic [SUM_W-1:0]  tree_sum;

    modport master (
        output mem_rd, mem_addr, tree_clr, tree_valid,
        input  tree_sum
    );

    modport slave (
        input  mem_rd, mem_addr, tree_clr, tree_valid,
        output tree_sum
    );

endinterface

// File: rtl/valid_delay.sv
// Clearable shift register that aligns the read strobe with the memory
// read latency.
module valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic in_i,
    output logic out_o
);

    if (DEPTH == 0) begin : g_passthru
        assign out_o = in_i;
    end else begin : g_shift
        logic [DEPTH-1:0] sr_q;

        // Shift the strobe in; reset or clear flushes every stage at once.
        always_ff @(posedge clk) begin
            if (rst || clr_i) begin
                sr_q <= '0;
            end else begin
                sr_q <= (sr_q << 1) | DEPTH'(in_i);
            end
        end

        assign out_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/avg_sequencer.sv
// Sequencer for one averaging run: clear the adder tree, stream BEATS
// reads through it, wait for the tree to settle, then latch the rounded
// average.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_CLEAR | one cycle of tree_clr
//   ST_FEED  | BEATS cycles of mem_rd, mem_addr = beat index
//   ST_DRAIN | MEM_LAT+TREE_LAT cycles for data to reach tree_sum
//   ST_DONE  | one cycle, done pulse; avg loaded on entry
module avg_sequencer
    import avg_pkg::*;
#(
    parameter int BEATS    = 32,
    parameter int MEM_LAT  = 1,
    parameter int TREE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                abort_i,
    avg_sequencer_if.master     bus,
    output logic [AVG_W-1:0]    avg_o,
    output logic                avg_valid_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int DRAIN_LEN = MEM_LAT + TREE_LAT;
    localparam int DRAIN_W   = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_LEN - 1);
    localparam logic [ADDR_W-1:0]  LAST_BEAT  = ADDR_W'(BEATS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   beat_q, beat_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [AVG_W-1:0]    avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                mem_rd_q, tree_clr_q, busy_q, done_q;

    // Next state, counters and result capture.
    always_comb begin
        state_d     = state_q;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;

        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_FEED;
            ST_FEED:  if (beat_q == LAST_BEAT) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Abort wins everywhere, including against start in IDLE.
        if (abort_i) state_d = ST_IDLE;

        // Beat index doubles as mem_addr, so it sits at zero outside FEED.
        beat_d  = (state_q == ST_FEED && state_d == ST_FEED) ? beat_q + 1'b1 : '0;
        drain_d = (state_q == ST_DRAIN) ? drain_q - 1'b1 : DRAIN_INIT;

        if (state_q == ST_IDLE && state_d == ST_CLEAR) avg_valid_d = 1'b0;
        if (state_d == ST_DONE) begin
            avg_d       = round_avg(bus.tree_sum);
            avg_valid_d = 1'b1;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            drain_q     <= DRAIN_INIT;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            tree_clr_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            drain_q     <= drain_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            mem_rd_q    <= (state_d == ST_FEED);
            tree_clr_q  <= (state_d == ST_CLEAR);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    valid_delay #(.DEPTH(MEM_LAT)) u_valid_delay (
        .clk   (clk),
        .rst   (rst),
        .clr_i (abort_i),
        .in_i  (mem_rd_q),
        .out_o (bus.tree_valid)
    );

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = beat_q;
    assign bus.tree_clr = tree_clr_q;
    assign avg_o        = avg_q;
    assign avg_valid_o  = avg_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_avg_sequencer.sv
// Bench for avg_sequencer: sample memory plus adder-tree model on the bus,
// run-level timeline and average checked against a cycle-count reference.
module tb_avg_sequencer;

    localparam int BEATS = 32;
    localparam int ML    = 1;
    localparam int TL    = 3;
    localparam int NCYC  = 45;
    localparam int DK    = 2 + BEATS + ML + TL;   // cycle of the done pulse

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] avg;
    logic       avg_valid, busy, done;

    avg_sequencer_if bus();

    avg_sequencer #(.BEATS(BEATS), .MEM_LAT(ML), .TREE_LAT(TL)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .abort_i     (abort),
        .bus         (bus),
        .avg_o       (avg),
        .avg_valid_o (avg_valid),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Sample memory and adder tree environment
    logic [7:0]  mem [BEATS][8];
    logic [10:0] lane_sum_q;
    logic [15:0] acc_q, d1_q, d2_q;
    logic        force_en;
    logic [15:0] force_val;

    function automatic logic [10:0] lane_total(input logic [4:0] a);
        logic [10:0] s = '0;
        for (int l = 0; l < 8; l++) s = s + 11'(mem[a][l]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd) lane_sum_q <= lane_total(bus.mem_addr);
        if (bus.tree_clr)        acc_q <= '0;
        else if (bus.tree_valid) acc_q <= acc_q + 16'(lane_sum_q);
        d1_q <= acc_q;
        d2_q <= d1_q;
    end

    assign bus.tree_sum = force_en ? force_val : d2_q;

    // Reference model
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] model_avg;
    logic       model_valid;

    function automatic logic [7:0] ref_avg();
        int s = 0;
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < 8; l++) s += int'(mem[b][l]);
        return 8'((s + 128) / 256);
    endfunction

    // {tree_clr, mem_rd, mem_addr[4:0], tree_valid, busy, done, avg_valid}
    function automatic logic [10:0] exp_vec(input int k, input int abort_k,
                                            input int rst_k, input logic prev_valid);
        int kill = 1000;
        logic clr, rd, tv, bsy, dn, av;
        logic [4:0] addr;
        if (abort_k >= 0) kill = abort_k + 1;
        if (rst_k >= 0)   kill = rst_k + 1;
        if (k >= kill) begin
            av = (rst_k < 0 && kill == 1) ? prev_valid : 1'b0;
            return {10'b0, av};
        end
        clr  = (k == 1);
        rd   = (k >= 2) && (k <= 1 + BEATS);
        addr = rd ? 5'(k - 2) : 5'd0;
        tv   = (k >= 2 + ML) && (k <= 1 + BEATS + ML);
        bsy  = (k >= 1) && (k <= DK);
        dn   = (k == DK);
        av   = (k == 0) ? prev_valid : (k >= DK);
        return {clr, rd, addr, tv, bsy, dn, av};
    endfunction

    // Run driver: records observations, checks nothing itself
    logic [10:0] obs [NCYC];
    int          tv_cnt, done_cnt;
    logic [7:0]  end_avg;

    task automatic run_cycles(input int abort_k, input int rst_k, input int start2_k);
        tv_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        for (int k = 0; k < NCYC; k++) begin
            obs[k] = {bus.tree_clr, bus.mem_rd, bus.mem_addr, bus.tree_valid,
                      busy, done, avg_valid};
            if (bus.tree_valid) tv_cnt++;
            if (done) done_cnt++;
            start = (k == 0) || (k == start2_k);
            abort = (k == abort_k);
            rst   = (k == rst_k);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        end_avg = avg;
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < 8; l++) mem[b][l] = v;
    endtask

    task automatic fill_rand();
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < 8; l++) mem[b][l] = 8'($urandom_range(0, 255));
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        @(negedge clk); @(negedge clk);
        start = 1'b0;
        total_cnt++; if (bus.mem_rd !== 1'b0)     $display("FAIL reset_mem_rd got %b exp 0", bus.mem_rd); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 5'd0)   $display("FAIL reset_mem_addr got %0d exp 0", bus.mem_addr); else pass_cnt++;
        total_cnt++; if (bus.tree_clr !== 1'b0)   $display("FAIL reset_tree_clr got %b exp 0", bus.tree_clr); else pass_cnt++;
        total_cnt++; if (bus.tree_valid !== 1'b0) $display("FAIL reset_tree_valid got %b exp 0", bus.tree_valid); else pass_cnt++;
        total_cnt++; if (avg !== 8'd0)            $display("FAIL reset_avg got %0d exp 0", avg); else pass_cnt++;
        total_cnt++; if (avg_valid !== 1'b0)      $display("FAIL reset_avg_valid got %b exp 0", avg_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)           $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0)           $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        rst = 1'b0;
        model_avg = 8'd0;
        model_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run(input string name, input logic use_rand, input logic [7:0] v);
        logic [7:0]  exp_avg;
        logic [10:0] e;
        if (use_rand) fill_rand(); else fill_const(v);
        exp_avg = ref_avg();
        run_cycles(-1, -1, -1);
        for (int k = 0; k < NCYC; k++) begin
            e = exp_vec(k, -1, -1, model_valid);
            total_cnt++;
            if (obs[k] !== e) $display("FAIL %s timeline k=%0d got %b exp %b", name, k, obs[k], e);
            else pass_cnt++;
        end
        total_cnt++; if (end_avg !== exp_avg) $display("FAIL %s avg got %0d exp %0d", name, end_avg, exp_avg); else pass_cnt++;
        total_cnt++; if (tv_cnt != BEATS) $display("FAIL %s beats got %0d exp %0d", name, tv_cnt, BEATS); else pass_cnt++;
        model_avg = exp_avg;
        model_valid = 1'b1;
    endtask

    task automatic test_rounding(input logic [15:0] sum, input logic [7:0] exp_avg);
        force_en = 1'b1;
        force_val = sum;
        run_cycles(-1, -1, -1);
        force_en = 1'b0;
        total_cnt++;
        if (end_avg !== exp_avg) $display("FAIL rounding sum=%0d got %0d exp %0d", sum, end_avg, exp_avg);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL rounding done_count got %0d exp 1", done_cnt); else pass_cnt++;
        model_avg = exp_avg;
        model_valid = 1'b1;
    endtask

    task automatic test_abort_start_idle();
        logic [10:0] e;
        run_cycles(0, -1, -1);
        for (int k = 0; k < NCYC; k++) begin
            e = exp_vec(k, 0, -1, model_valid);
            total_cnt++;
            if (obs[k] !== e) $display("FAIL abort_idle timeline k=%0d got %b exp %b", k, obs[k], e);
            else pass_cnt++;
        end
        total_cnt++; if (end_avg !== model_avg) $display("FAIL abort_idle avg got %0d exp %0d", end_avg, model_avg); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [10:0] e;
        fill_rand();
        run_cycles(20, -1, -1);
        for (int k = 0; k < NCYC; k++) begin
            e = exp_vec(k, 20, -1, model_valid);
            total_cnt++;
            if (obs[k] !== e) $display("FAIL abort timeline k=%0d got %b exp %b", k, obs[k], e);
            else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 0) $display("FAIL abort done_count got %0d exp 0", done_cnt); else pass_cnt++;
        total_cnt++; if (end_avg !== model_avg) $display("FAIL abort avg_kept got %0d exp %0d", end_avg, model_avg); else pass_cnt++;
        model_valid = 1'b0;
    endtask

    task automatic test_rst_midrun();
        logic [10:0] e;
        fill_rand();
        run_cycles(-1, 10, -1);
        for (int k = 0; k < NCYC; k++) begin
            e = exp_vec(k, -1, 10, model_valid);
            total_cnt++;
            if (obs[k] !== e) $display("FAIL rst_midrun timeline k=%0d got %b exp %b", k, obs[k], e);
            else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 0) $display("FAIL rst_midrun done_count got %0d exp 0", done_cnt); else pass_cnt++;
        total_cnt++; if (end_avg !== 8'd0) $display("FAIL rst_midrun avg got %0d exp 0", end_avg); else pass_cnt++;
        model_avg = 8'd0;
        model_valid = 1'b0;
    endtask

    task automatic test_start_in_feed();
        logic [7:0]  exp_avg;
        logic [10:0] e;
        fill_rand();
        exp_avg = ref_avg();
        run_cycles(-1, -1, 15);
        for (int k = 0; k < NCYC; k++) begin
            e = exp_vec(k, -1, -1, model_valid);
            total_cnt++;
            if (obs[k] !== e) $display("FAIL start_in_feed timeline k=%0d got %b exp %b", k, obs[k], e);
            else pass_cnt++;
        end
        total_cnt++; if (tv_cnt != BEATS) $display("FAIL start_in_feed beats got %0d exp %0d", tv_cnt, BEATS); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL start_in_feed done_count got %0d exp 1", done_cnt); else pass_cnt++;
        total_cnt++; if (end_avg !== exp_avg) $display("FAIL start_in_feed avg got %0d exp %0d", end_avg, exp_avg); else pass_cnt++;
        model_avg = exp_avg;
        model_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        force_en = 1'b0; force_val = 16'd0;
        fill_const(8'd0);
        test_reset();
        test_run("nominal", 1'b0, 8'd1);
        test_run("full_scale", 1'b0, 8'd255);
        for (int i = 0; i < 3; i++) test_run("random", 1'b1, 8'd0);
        test_rounding(16'd383, 8'd1);
        test_rounding(16'd127, 8'd0);
        test_rounding(16'd384, 8'd2);
        test_abort_start_idle();
        test_abort();
        test_rst_midrun();
        test_run("after_rst", 1'b1, 8'd0);
        test_start_in_feed();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/avg_sequencer.md
AVG_SEQUENCER -- requirements
Module: avg_sequencer

Interface
REQ-001 Parameter BEATS, default 32: number of sample beats fed to the adder tree per run.
REQ-002 Parameter MEM_LAT, default 1: cycles from mem_rd to read data being valid at the adder tree inputs.
REQ-003 Parameter TREE_LAT, default 3: cycles from the last valid beat to the final value on tree_sum.
REQ-004 clk  input  1  sole clock; all logic SHALL be on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 abort  input  1  cancels any run in progress.
REQ-008 mem_rd  output  1  read strobe to the 8-lane sample memory.
REQ-009 mem_addr  output  5  beat index for the read.
REQ-010 tree_clr  output  1  clears the adder tree accumulator.
REQ-011 tree_valid  output  1  drives the adder tree in_valid.
REQ-012 tree_sum  input  16  accumulated sum of 8 lanes x BEATS samples.
REQ-013 avg  output  8  rounded average, registered.
REQ-014 avg_valid  output  1  avg holds the result of a completed run.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-018 IDLE->CLEAR SHALL occur on start=1 with abort=0; start SHALL be ignored in all other states.
REQ-019 CLEAR SHALL last 1 cycle with tree_clr=1, then go to FEED.
REQ-020 FEED SHALL last exactly BEATS cycles with mem_rd=1 and mem_addr=0,1,...,BEATS-1, then go to DRAIN.
REQ-021 tree_valid SHALL equal mem_rd delayed by MEM_LAT cycles through a shift register; it SHALL be 1 for exactly BEATS cycles per run.
REQ-022 DRAIN SHALL last MEM_LAT+TREE_LAT cycles, counted from the cycle after the last mem_rd, then go to DONE.
REQ-023 On the edge entering DONE, avg SHALL load (tree_sum+128)>>8 computed at 17 bits (range 0..255, no overflow) and avg_valid SHALL set.
REQ-024 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-025 With the default parameters: start sampled at cycle 0 -> CLEAR at 1, FEED at 2..33, DRAIN at 34..37, DONE at 38.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle, clear the tree_valid pipeline, suppress done, and leave avg and avg_valid unchanged.
REQ-027 abort and start both high in IDLE: abort SHALL win and no run SHALL start.
REQ-028 start SHALL clear avg_valid on the IDLE->CLEAR edge.
REQ-029 The beat counter SHALL not wrap: BEATS SHALL be at most 32, and mem_addr SHALL be 0 outside FEED.
REQ-030 mem_rd, tree_clr, tree_valid and done SHALL be registered outputs with no combinational path from start or abort.

Reset
REQ-031 rst=1 SHALL, on the next edge, force IDLE and set mem_rd=0, mem_addr=0, tree_clr=0, tree_valid=0 (whole pipeline), avg=0, avg_valid=0, busy=0 and done=0.
REQ-032 rst SHALL take priority over start and abort, and reset mid-run SHALL discard the run with no done pulse.

Structure
REQ-033 The state encoding and the rounding constant 128 SHALL be in the shared package avg_pkg.
REQ-034 The sequencer SHALL not instantiate adder_tree; the top level SHALL connect tree_clr, tree_valid and tree_sum to it.
REQ-035 The MEM_LAT delay line SHALL be a single sub-module, valid_delay, parameterised by depth.

Verification
REQ-036 Nominal: start at cycle 0 with a tree model summing lanes all = 1 -> tree_sum=256, done at cycle 38, avg=1, avg_valid=1.
REQ-037 Full scale: all samples 255 -> tree_sum=65280, avg=255, no overflow.
REQ-038 Rounding: forced tree_sum 383 -> avg=1; tree_sum 384 -> avg=2; tree_sum 127 -> avg=0.
REQ-039 Abort at cycle 20 -> IDLE at 21, tree_valid=0 by cycle 22, no done, previous avg kept.
REQ-040 rst at cycle 10 of a run -> all outputs at reset values next cycle; a following start completes normally.
REQ-041 start pulsed during FEED -> ignored, exactly 32 tree_valid beats, one done.
